uart_tx_arbiter: RTL and testbench

- Shares one uart_tx_sol transmitter between two byte sources: channel A (e.g. bytes forwarded from the gold board) and channel B (e.g. locally generated status/echo bytes).
- Each channel has its own FIFO, which replaces the single-byte buffer plus overflow-prone state logic in the bridge top level.
- A round-robin scheduler pulses the transmitter's en one byte at a time and tracks its rdy handshake.
- Overflow is reported per channel, never silently merged.

---
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two byte FIFOs sharing one uart_tx_sol transmitter.
// Build option UART_TX_ARB_PRIO_A_EN: fixed A-over-B priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int DEPTH        = 8,
    parameter int AW           = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [7:0]  a_data,
    input  logic        b_valid,
    input  logic [7:0]  b_data,
    input  logic        tx_rdy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic [AW:0] a_level,
    output logic [AW:0] b_level,
    output logic        a_ovf,
    output logic        b_ovf,
    input  logic        ovf_clr,
    output logic        busy,
    output logic        last_src
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [AW:0] FULL_LV = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_RDY
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;

    logic [7:0]  r_a_mem [DEPTH];
    logic [7:0]  r_b_mem [DEPTH];
    logic [AW:0] r_a_wr;
    logic [AW:0] r_a_rd;
    logic [AW:0] r_b_wr;
    logic [AW:0] r_b_rd;

    logic        r_tx_en;
    logic [7:0]  r_tx_data;
    logic        r_busy;
    logic        r_last_src;
    logic        r_a_ovf;
    logic        r_b_ovf;

    logic        w_a_ne;
    logic        w_b_ne;
    logic        w_a_full;
    logic        w_b_full;
    logic        w_grant;
    logic        w_pick_b;
    logic        w_a_pop;
    logic        w_b_pop;
    logic        w_a_push;
    logic        w_b_push;
    logic        w_a_drop;
    logic        w_b_drop;
    logic [7:0]  w_a_head;
    logic [7:0]  w_b_head;

    assign a_level  = r_a_wr - r_a_rd;
    assign b_level  = r_b_wr - r_b_rd;
    assign w_a_ne   = (a_level != '0);
    assign w_b_ne   = (b_level != '0);
    assign w_a_full = (a_level == FULL_LV);
    assign w_b_full = (b_level == FULL_LV);
    assign w_a_head = r_a_mem[r_a_rd[AW-1:0]];
    assign w_b_head = r_b_mem[r_b_rd[AW-1:0]];

`ifdef UART_TX_ARB_PRIO_A_EN
    assign w_pick_b = !w_a_ne;
`else
    // B only when A is empty or it is B's turn after an A grant
    assign w_pick_b = w_b_ne && (!w_a_ne || !r_last_src);
`endif

    assign w_grant = (r_state == S_IDLE) && tx_rdy && (w_a_ne || w_b_ne);
    assign w_a_pop = w_grant && !w_pick_b;
    assign w_b_pop = w_grant && w_pick_b;

    // a full FIFO still takes a push when the grant frees a slot this cycle
    assign w_a_push = a_valid && (!w_a_full || w_a_pop);
    assign w_b_push = b_valid && (!w_b_full || w_b_pop);
    assign w_a_drop = a_valid && w_a_full && !w_a_pop;
    assign w_b_drop = b_valid && w_b_full && !w_b_pop;

    always_ff @(posedge clk) begin
        if (w_a_push) r_a_mem[r_a_wr[AW-1:0]] <= a_data;
        if (w_b_push) r_b_mem[r_b_wr[AW-1:0]] <= b_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_wr  <= '0;
            r_a_rd  <= '0;
            r_b_wr  <= '0;
            r_b_rd  <= '0;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else begin
            if (w_a_push) r_a_wr <= r_a_wr + 1'b1;
            if (w_a_pop)  r_a_rd <= r_a_rd + 1'b1;
            if (w_b_push) r_b_wr <= r_b_wr + 1'b1;
            if (w_b_pop)  r_b_rd <= r_b_rd + 1'b1;

            if (w_a_drop)     r_a_ovf <= 1'b1;
            else if (ovf_clr) r_a_ovf <= 1'b0;
            if (w_b_drop)     r_b_ovf <= 1'b1;
            else if (ovf_clr) r_b_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_last_src <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_tx_data  <= w_pick_b ? w_b_head : w_a_head;
                        r_last_src <= w_pick_b;
                        r_tx_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tx_en <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!tx_rdy) begin
                        r_state <= S_WAIT_RDY;
                    end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (tx_rdy) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_en    = r_tx_en;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign last_src = r_last_src;
    assign a_ovf    = r_a_ovf;
    assign b_ovf    = r_b_ovf;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random traffic against a queue-based
// reference of the arbiter, with a simple busy-frame transmitter responder.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TO    = 4;
    localparam int BIG   = 32'h7fffffff;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0;
    logic [7:0]    a_data = 8'h00;
    logic          b_valid = 1'b0;
    logic [7:0]    b_data = 8'h00;
    logic          tx_rdy = 1'b1;
    logic          ovf_clr = 1'b0;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic [AW:0]   a_level;
    logic [AW:0]   b_level;
    logic          a_ovf;
    logic          b_ovf;
    logic          busy;
    logic          last_src;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DEPTH(DEPTH),
        .AW(AW),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_valid(a_valid),
        .a_data(a_data),
        .b_valid(b_valid),
        .b_data(b_data),
        .tx_rdy(tx_rdy),
        .tx_en(tx_en),
        .tx_data(tx_data),
        .a_level(a_level),
        .b_level(b_level),
        .a_ovf(a_ovf),
        .b_ovf(b_ovf),
        .ovf_clr(ovf_clr),
        .busy(busy),
        .last_src(last_src)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // reference: per-channel queues plus grant timestamps
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         m_e = 0;
    int         m_free_at = 0;
    int         m_g = -100;
    int         m_d = -1;
    logic       m_en = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_last = 1'b1;
    logic       m_aovf = 1'b0;
    logic       m_bovf = 1'b0;

    // transmitter responder
    bit rdy_hold = 0;
    bit rdy_stuck = 0;
    bit tx_seen = 0;
    int frame_cnt = 0;
    int fmin = 10;
    int fmax = 10;

    logic [7:0] em[$];
    int         em_e[$];
    logic [7:0] exp_q[$];

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_free_at = 0;
        m_g = -100;
        m_d = -1;
        m_en = 1'b0;
        m_data = 8'h00;
        m_last = 1'b1;
        m_aovf = 1'b0;
        m_bovf = 1'b0;
    endtask

    task automatic model_step();
        bit grant, pick_b, pop_a, pop_b;
        int sa, sb;
        m_e++;
        sa = qa.size();
        sb = qb.size();
        grant = (m_e >= m_free_at) && tx_rdy && (sa + sb > 0);
`ifdef UART_TX_ARB_PRIO_A_EN
        pick_b = (sa == 0);
`else
        pick_b = (sa == 0) || (sb > 0 && m_last == 1'b0);
`endif
        pop_a = grant && !pick_b;
        pop_b = grant && pick_b;
        m_en = grant;
        if (grant) begin
            m_data = pick_b ? qb.pop_front() : qa.pop_front();
            m_last = pick_b;
            m_g = m_e;
            m_d = -1;
            m_free_at = BIG;
        end else if (m_free_at == BIG && m_e >= m_g + 2) begin
            if (m_d < 0) begin
                if (!tx_rdy) m_d = m_e;
                else if (m_e == m_g + TO + 1) m_free_at = m_e + 1;
            end else if (tx_rdy) begin
                m_free_at = m_e + 1;
            end
        end
        if (a_valid && sa >= DEPTH && !pop_a) m_aovf = 1'b1;
        else if (ovf_clr) m_aovf = 1'b0;
        if (b_valid && sb >= DEPTH && !pop_b) m_bovf = 1'b1;
        else if (ovf_clr) m_bovf = 1'b0;
        if (a_valid && (sa < DEPTH || pop_a)) qa.push_back(a_data);
        if (b_valid && (sb < DEPTH || pop_b)) qb.push_back(b_data);
    endtask

    task automatic cycle(input logic av, input logic [7:0] ad,
                         input logic bv, input logic [7:0] bd,
                         input logic clr);
        if (rdy_hold) begin
            tx_rdy = 1'b0;
        end else if (rdy_stuck) begin
            tx_rdy = 1'b1;
        end else if (tx_seen) begin
            tx_rdy = 1'b0;
            frame_cnt = $urandom_range(fmax, fmin);
        end else if (frame_cnt > 0) begin
            frame_cnt--;
            if (frame_cnt == 0) tx_rdy = 1'b1;
        end else begin
            tx_rdy = 1'b1;
        end
        tx_seen = tx_en;
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        ovf_clr = clr;
        model_step();
        @(negedge clk);
        chk("tx_en", tx_en, m_en);
        chk("tx_data", tx_data, m_data);
        chk("a_level", a_level, qa.size());
        chk("b_level", b_level, qb.size());
        chk("a_ovf", a_ovf, m_aovf);
        chk("b_ovf", b_ovf, m_bovf);
        chk("busy", busy, m_free_at > m_e + 1);
        chk("last_src", last_src, m_last);
        if (tx_en) begin
            em.push_back(tx_data);
            em_e.push_back(m_e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push_a(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_em(input string tag);
        chk({tag, "_count"}, em.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < em.size()) chk(tag, em[i], exp_q[i]);
        end
        em.delete();
        em_e.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        ovf_clr = 1'b0;
        #1;
        chk("rst_tx_en", tx_en, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_a_level", a_level, 0);
        chk("rst_b_level", b_level, 0);
        chk("rst_ovf", {a_ovf, b_ovf}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last_src", last_src, 1'b1);
        model_reset();
        tx_rdy = 1'b1;
        frame_cnt = 0;
        tx_seen = 0;
        rdy_hold = 0;
        rdy_stuck = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        em.delete();
        em_e.delete();
    endtask

    initial begin
        int p;
        int mode;
        @(negedge clk);
        do_reset();

        // single byte and its latency
        push_a(8'h41);
        p = m_e;
        idle(25);
        chk("single_lat_n", em_e.size(), 1);
        if (em_e.size() > 0) chk("single_lat", em_e[0], p + 1);
        chk("single_last", last_src, 1'b0);
        exp_q = '{8'h41};
        chk_em("single");

        // tie after reset, then refill with both channels
        do_reset();
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        push_a(8'h12);
        push_a(8'h13);
        idle(80);
`ifdef UART_TX_ARB_PRIO_A_EN
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h22};
`else
        exp_q = '{8'h11, 8'h22, 8'h12, 8'h13};
`endif
        chk_em("tie");
        cycle(1'b1, 8'h31, 1'b1, 8'h41, 1'b0);
        cycle(1'b1, 8'h32, 1'b1, 8'h42, 1'b0);
        idle(80);
`ifdef UART_TX_ARB_PRIO_A_EN
        exp_q = '{8'h31, 8'h32, 8'h41, 8'h42};
`else
        exp_q = '{8'h41, 8'h31, 8'h42, 8'h32};
`endif
        chk_em("refill");

        // overflow while transmitter is held busy
        do_reset();
        rdy_hold = 1;
        for (int i = 0; i < 9; i++) push_a(8'(i));
        chk("ovf_level", a_level, 8);
        chk("ovf_a", a_ovf, 1'b1);
        chk("ovf_b", b_ovf, 1'b0);
        rdy_hold = 0;
        idle(200);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        chk_em("ovf_order");

        // full FIFO pushed in the grant cycle
        do_reset();
        rdy_hold = 1;
        for (int i = 0; i < 8; i++) push_a(8'(8'h60 + i));
        rdy_hold = 0;
        push_a(8'h55);
        chk("fullpp_level", a_level, 8);
        chk("fullpp_ovf", a_ovf, 1'b0);
        idle(200);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h60 + i));
        exp_q.push_back(8'h55);
        chk_em("fullpp_order");

        // clear versus coincident overflow
        do_reset();
        rdy_hold = 1;
        for (int i = 0; i < 9; i++) push_a(8'(8'h70 + i));
        chk("clr_set", a_ovf, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("clr_only", a_ovf, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
        chk("clr_vs_ovf", a_ovf, 1'b1);
        chk("clr_vs_ovf_b", b_ovf, 1'b0);
        rdy_hold = 0;
        idle(200);
        em.delete();
        em_e.delete();

        // transmitter never drops rdy
        do_reset();
        rdy_stuck = 1;
        push_a(8'ha1);
        push_a(8'ha2);
        idle(30);
        chk("timeout_n", em_e.size(), 2);
        if (em_e.size() >= 2) chk("timeout_gap", em_e[1] - em_e[0], TO + 2);
        exp_q = '{8'ha1, 8'ha2};
        chk_em("timeout_order");
        rdy_stuck = 0;

        // reset while tx_en is high
        do_reset();
        push_a(8'h77);
        idle(1);
        chk("issue_en", tx_en, 1'b1);
        do_reset();
        idle(20);
        chk("post_rst_issue", em.size(), 0);

        // reset while waiting for rdy with bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) push_a(8'(8'hb0 + i));
        for (int k = 0; k < 20 && !(busy && !tx_rdy); k++) idle(1);
        chk("wait_rdy_seen", busy && !tx_rdy, 1'b1);
        chk("wait_rdy_level", a_level, 3);
        do_reset();
        idle(40);
        chk("post_rst_wait", em.size(), 0);

        // random traffic
        do_reset();
        fmin = 1;
        fmax = 12;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                mode = $urandom_range(5, 0);
                rdy_stuck = (mode == 0);
                rdy_hold  = (mode == 1);
            end
            cycle(($urandom % 4) == 0, 8'($urandom),
                  ($urandom % 4) == 0, 8'($urandom),
                  ($urandom % 40) == 0);
        end
        rdy_hold = 0;
        rdy_stuck = 0;
        idle(300);
        chk("drain_a", a_level, 0);
        chk("drain_b", b_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
